roi_feature_extract: RTL and testbench

ROI_FEATURE_EXTRACT -- requirements
Module: roi_feature_extract

---
 rtl/roi_feature_extract.sv | 144 ++++++++++++++
 tb/tb_roi_feature_extract.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/roi_feature_extract.sv
// roi_feature_extract: RGB565 pixel pipeline that accumulates per-frame ROI dark/bright/grey-histogram features.
// Optional ROI border overlay on out_data when ROI_FEATURE_OVERLAY_EN is defined.
module roi_feature_extract #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ROI_X0 = 170,
  parameter int ROI_Y0 = 90,
  parameter int ROI_W  = 300,
  parameter int ROI_H  = 300,
  parameter int NBIN   = 4,
  parameter int CNT_W  = 20
) (
  input  logic                    cam_pclk,
  input  logic                    rst_n,
  input  logic                    pix_valid,
  input  logic                    pix_href,
  input  logic [15:0]             pix_data,
  input  logic [7:0]              thresh,
  input  logic                    feat_ready,
  output logic                    out_valid,
  output logic [15:0]             out_data,
  output logic                    feat_valid,
  output logic [CNT_W-1:0]        feat_dark,
  output logic [CNT_W-1:0]        feat_bright,
  output logic [NBIN*CNT_W-1:0]   feat_hist,
  output logic                    frame_done,
  output logic                    feat_overrun
);
  localparam int HW = $clog2(H_ACT + 1);
  localparam int VW = $clog2(V_ACT + 1);
  localparam int LB = $clog2(NBIN);
  localparam logic [0:0] S_SYNC = 1'b0, S_ACT = 1'b1, F_IDLE = 1'b0, F_HOLD = 1'b1;

  logic                  sync_q, sync_d, href_q, href_fall;
  logic [HW-1:0]         h_q, h_d, x1_q;
  logic [VW-1:0]         v_q, v_d, y1_q;
  logic                  v1_q, a1_q;
  logic [15:0]           d1_q, out_data_q, out_data_d;
  logic [7:0]            th1_q, grey;
  logic [LB-1:0]         bin;
  logic                  out_valid_q, in_roi, last, dark_hit;
  logic [CNT_W-1:0]      dark_q, dark_d, bright_q, bright_d, fdark_q, fbright_q;
  logic [NBIN*CNT_W-1:0] hist_q, hist_d, fhist_q;
  logic                  feat_q, feat_d, done_q, ovr_q, ovr_d;

  assign href_fall = href_q & ~pix_href;

  // Line position is unknown until the first line end after reset.
  always_comb begin
    sync_d = (sync_q == S_SYNC && href_fall) ? S_ACT : sync_q;
    h_d = href_fall ? '0 : (sync_q == S_ACT && pix_valid && !(&h_q)) ? h_q + HW'(1) : h_q;
    v_d = (sync_q == S_SYNC) ? '0 : !href_fall ? v_q : (v_q == VW'(V_ACT - 1)) ? '0 : v_q + VW'(1);
  end

  assign grey = {2'b0, d1_q[15:11], 1'b0} + {1'b0, d1_q[10:5], 1'b0} + {2'b0, d1_q[4:0], 1'b0};
  assign bin = grey[7 -: LB];
  assign in_roi = v1_q && a1_q && int'(x1_q) >= ROI_X0 && int'(x1_q) < ROI_X0 + ROI_W
                  && int'(y1_q) >= ROI_Y0 && int'(y1_q) < ROI_Y0 + ROI_H;
  assign last = v1_q && a1_q && x1_q == HW'(H_ACT - 1) && y1_q == VW'(V_ACT - 1);
  assign dark_hit = in_roi && grey < th1_q;
  assign dark_d = dark_q + CNT_W'(dark_hit && !(&dark_q));
  assign bright_d = bright_q + CNT_W'(in_roi && !dark_hit && !(&bright_q));

  always_comb begin
    hist_d = hist_q;
    for (int k = 0; k < NBIN; k++)
      hist_d[k*CNT_W +: CNT_W] = hist_q[k*CNT_W +: CNT_W]
        + CNT_W'(in_roi && int'(bin) == k && !(&hist_q[k*CNT_W +: CNT_W]));
  end

  // A snapshot always wins; an unconsumed previous one is overwritten and flagged.
  assign feat_d = last ? F_HOLD : (feat_q == F_HOLD && feat_ready) ? F_IDLE : feat_q;
  assign ovr_d = last && feat_q == F_HOLD && !feat_ready;

`ifdef ROI_FEATURE_OVERLAY_EN
  logic on_v, on_h;
  always_comb begin
    on_v = (int'(x1_q) == ROI_X0 - 1 || int'(x1_q) == ROI_X0 + ROI_W)
           && int'(y1_q) >= ROI_Y0 - 1 && int'(y1_q) <= ROI_Y0 + ROI_H;
    on_h = (int'(y1_q) == ROI_Y0 - 1 || int'(y1_q) == ROI_Y0 + ROI_H)
           && int'(x1_q) >= ROI_X0 - 1 && int'(x1_q) <= ROI_X0 + ROI_W;
    out_data_d = (a1_q && (on_v || on_h)) ? 16'h0000 : d1_q;
  end
`else
  assign out_data_d = d1_q;
`endif

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= S_SYNC;
      href_q      <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      v1_q        <= 1'b0;
      a1_q        <= 1'b0;
      d1_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      th1_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      dark_q      <= '0;
      bright_q    <= '0;
      hist_q      <= '0;
      fdark_q     <= '0;
      fbright_q   <= '0;
      fhist_q     <= '0;
      feat_q      <= F_IDLE;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      href_q      <= pix_href;
      h_q         <= h_d;
      v_q         <= v_d;
      v1_q        <= pix_valid;
      a1_q        <= sync_q == S_ACT;
      d1_q        <= pix_data;
      x1_q        <= h_q;
      y1_q        <= v_q;
      th1_q       <= thresh;
      out_valid_q <= v1_q;
      out_data_q  <= out_data_d;
      dark_q      <= last ? '0 : dark_d;
      bright_q    <= last ? '0 : bright_d;
      hist_q      <= last ? '0 : hist_d;
      fdark_q     <= last ? dark_d : fdark_q;
      fbright_q   <= last ? bright_d : fbright_q;
      fhist_q     <= last ? hist_d : fhist_q;
      feat_q      <= feat_d;
      done_q      <= last;
      ovr_q       <= ovr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign feat_valid   = feat_q == F_HOLD;
  assign feat_dark    = fdark_q;
  assign feat_bright  = fbright_q;
  assign feat_hist    = fhist_q;
  assign frame_done   = done_q;
  assign feat_overrun = ovr_q;
endmodule

// File: tb/tb_roi_feature_extract.sv
// tb_roi_feature_extract: directed frames on an 8x4 sensor with a 4x2 ROI, plus a 3-bit counter instance for saturation.
`timescale 1ns/1ps
module tb_roi_feature_extract;
  localparam int H = 8, V = 4, CW = 20, NB = 4;
  logic cam_pclk = 1'b0, rst_n = 1'b1, pix_valid = 1'b0, pix_href = 1'b0, feat_ready = 1'b0;
  logic [15:0] pix_data = '0;
  logic [7:0] thresh = 8'd105;
  logic out_valid, feat_valid, frame_done, feat_overrun;
  logic [15:0] out_data;
  logic [CW-1:0] feat_dark, feat_bright;
  logic [NB*CW-1:0] feat_hist;
  logic s_valid, s_fvalid, s_done, s_ovr;
  logic [15:0] s_data;
  logic [2:0] s_dark, s_bright;
  logic [NB*3-1:0] s_hist;
  int total = 0, bad = 0, cyc = 0, fd_cnt = 0, ov_cnt = 0, mark_cyc = -100, fd0, ov0;
  logic cap_v = 1'b0;
  logic [15:0] cap_d = '0;

  roi_feature_extract #(.H_ACT(H), .V_ACT(V), .ROI_X0(2), .ROI_Y0(1), .ROI_W(4), .ROI_H(2)) u_dut (
    .cam_pclk(cam_pclk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_href(pix_href), .pix_data(pix_data),
    .thresh(thresh), .feat_ready(feat_ready), .out_valid(out_valid), .out_data(out_data),
    .feat_valid(feat_valid), .feat_dark(feat_dark), .feat_bright(feat_bright), .feat_hist(feat_hist),
    .frame_done(frame_done), .feat_overrun(feat_overrun));

  roi_feature_extract #(.H_ACT(H), .V_ACT(V), .ROI_X0(2), .ROI_Y0(1), .ROI_W(4), .ROI_H(2), .CNT_W(3)) u_sat (
    .cam_pclk(cam_pclk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_href(pix_href), .pix_data(pix_data),
    .thresh(thresh), .feat_ready(feat_ready), .out_valid(s_valid), .out_data(s_data),
    .feat_valid(s_fvalid), .feat_dark(s_dark), .feat_bright(s_bright), .feat_hist(s_hist),
    .frame_done(s_done), .feat_overrun(s_ovr));

  always #5 cam_pclk = ~cam_pclk;
  always @(posedge cam_pclk) cyc <= cyc + 1;
  always @(negedge cam_pclk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (feat_overrun) ov_cnt <= ov_cnt + 1;
    if (cyc == mark_cyc + 2) begin
      cap_v <= out_valid;
      cap_d <= out_data;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NB*CW-1:0] hv(input int b, input int n);
    hv = '0;
    hv[b*CW +: CW] = CW'(n);
  endfunction

  // y==0 with mk set puts a marker at x=1 so the 2-cycle output latency is observable.
  task automatic send_line(input logic [15:0] d, input int y, input bit mk, input int rst_x);
    for (int x = 0; x < H; x++) begin
      @(posedge cam_pclk); #1;
      if (x == rst_x) rst_n = 1'b0;
      pix_href = 1'b1;
      pix_valid = 1'b1;
      pix_data = (mk && y == 0) ? ((x == 1) ? 16'hFFFF : 16'h1000 + 16'(x)) : d;
      if (mk && y == 0 && x == 1) mark_cyc = cyc;
    end
    @(posedge cam_pclk); #1 pix_valid = 1'b0;
    @(posedge cam_pclk); #1 pix_href = 1'b0;
    repeat (3) @(posedge cam_pclk);
  endtask

  task automatic send_frame(input logic [15:0] d, input bit mk);
    fd0 = fd_cnt;
    ov0 = ov_cnt;
    for (int y = 0; y < V; y++) send_line(d, y, mk, -1);
    @(negedge cam_pclk);
  endtask

  task automatic consume();
    @(posedge cam_pclk); #1 feat_ready = 1'b1;
    @(posedge cam_pclk); #1 feat_ready = 1'b0;
    @(negedge cam_pclk);
    check("consume_valid", feat_valid, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge cam_pclk);
    @(negedge cam_pclk);
    check("rst_fvalid", feat_valid, 0);
    check("rst_dark", feat_dark, 0);
    check("rst_bright", feat_bright, 0);
    check("rst_hist", feat_hist, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovr", feat_overrun, 0);
    @(posedge cam_pclk); #1 rst_n = 1'b1;
    send_line(16'h0000, -1, 1'b0, -1);
    send_frame(16'h0000, 1'b0);
    check("f1_done", fd_cnt - fd0, 1);
    check("f1_fvalid", feat_valid, 1);
    check("f1_dark", feat_dark, 8);
    check("f1_bright", feat_bright, 0);
    check("f1_hist", feat_hist, hv(0, 8));
    check("sat_dark", s_dark, 7);
    check("sat_hist", s_hist, 12'd7);
    consume();
    send_frame(16'hFFFF, 1'b1);
    check("f2_ovr", ov_cnt - ov0, 0);
    check("f2_bright", feat_bright, 8);
    check("f2_dark", feat_dark, 0);
    check("f2_hist", feat_hist, hv(NB - 1, 8));
    check("mark_valid", cap_v, 1);
`ifdef ROI_FEATURE_OVERLAY_EN
    check("mark_data", cap_d, 16'h0000);
`else
    check("mark_data", cap_d, 16'hFFFF);
`endif
    thresh = 8'd128;
    send_frame(16'h8410, 1'b0);
    check("f3_ovr", ov_cnt - ov0, 1);
    check("f3_fvalid", feat_valid, 1);
    check("f3_bright", feat_bright, 8);
    check("f3_dark", feat_dark, 0);
    check("f3_hist", feat_hist, hv(2, 8));
    consume();
    thresh = 8'd129;
    send_frame(16'h8410, 1'b0);
    check("f4_ovr", ov_cnt - ov0, 0);
    check("f4_dark", feat_dark, 8);
    check("f4_hist", feat_hist, hv(2, 8));
    consume();
    fd0 = fd_cnt;
    send_line(16'h0000, 0, 1'b0, -1);
    send_line(16'h0000, 1, 1'b0, -1);
    send_line(16'h0000, 2, 1'b0, 4);
    @(negedge cam_pclk);
    check("mid_rst_fvalid", feat_valid, 0);
    check("mid_rst_dark", feat_dark, 0);
    @(posedge cam_pclk); #1 rst_n = 1'b1;
    send_line(16'hFFFF, 3, 1'b0, -1);
    check("resync_no_done", fd_cnt - fd0, 0);
    send_frame(16'h0000, 1'b0);
    check("f5_done", fd_cnt - fd0, 1);
    check("f5_fvalid", feat_valid, 1);
    check("f5_dark", feat_dark, 8);
    check("f5_bright", feat_bright, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
